// File: rtl/mouse_pos_pipe.sv
// mouse_pos_pipe: registered delay line for mouse x/y/left with freeze, edge pulses and position-change pulse.
// Optional coordinate clamp to X_MAX/Y_MAX when POS_CLAMP_EN is defined.
module mouse_pos_pipe #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 2,
  parameter int X_MAX = 1023,
  parameter int Y_MAX = 767
) (
  input  logic             pclk,
  input  logic             rst_n,
  input  logic             freeze,
  input  logic [WIDTH-1:0] xpos_in,
  input  logic [WIDTH-1:0] ypos_in,
  input  logic             mouse_left_in,
  output logic [WIDTH-1:0] xpos_out,
  output logic [WIDTH-1:0] ypos_out,
  output logic             mouse_left_out,
  output logic             left_press,
  output logic             left_release,
  output logic             pos_changed
);
  logic [WIDTH-1:0] cx, cy;
`ifdef POS_CLAMP_EN
  localparam logic [WIDTH-1:0] XLIM = WIDTH'(X_MAX);
  localparam logic [WIDTH-1:0] YLIM = WIDTH'(Y_MAX);
  assign cx = (xpos_in > XLIM) ? XLIM : xpos_in;
  assign cy = (ypos_in > YLIM) ? YLIM : ypos_in;
`else
  assign cx = xpos_in;
  assign cy = ypos_in;
`endif
  logic [WIDTH-1:0] x_q [DEPTH];
  logic [WIDTH-1:0] y_q [DEPTH];
  logic             l_q [DEPTH];
  logic [WIDTH-1:0] x0_d, y0_d;
  logic             l0_d;
  logic [WIDTH-1:0] nx, ny;
  logic             nl;
  logic             press_q, release_q, changed_q;
  assign x0_d = freeze ? x_q[0] : cx;
  assign y0_d = freeze ? y_q[0] : cy;
  assign l0_d = freeze ? l_q[0] : mouse_left_in;
  // value about to land in the last stage; with one stage that is the stage-0 load itself
  generate
    if (DEPTH == 1) begin : g_d1
      assign nx = x0_d;
      assign ny = y0_d;
      assign nl = l0_d;
    end else begin : g_dn
      assign nx = x_q[DEPTH-2];
      assign ny = y_q[DEPTH-2];
      assign nl = l_q[DEPTH-2];
    end
  endgenerate
  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        x_q[i] <= '0;
        y_q[i] <= '0;
        l_q[i] <= 1'b0;
      end
      press_q   <= 1'b0;
      release_q <= 1'b0;
      changed_q <= 1'b0;
    end else begin
      x_q[0] <= x0_d;
      y_q[0] <= y0_d;
      l_q[0] <= l0_d;
      for (int i = 1; i < DEPTH; i++) begin
        x_q[i] <= x_q[i-1];
        y_q[i] <= y_q[i-1];
        l_q[i] <= l_q[i-1];
      end
      press_q   <= !l_q[DEPTH-1] && nl;
      release_q <= l_q[DEPTH-1] && !nl;
      changed_q <= (nx != x_q[DEPTH-1]) || (ny != y_q[DEPTH-1]);
    end
  end
  assign xpos_out       = x_q[DEPTH-1];
  assign ypos_out       = y_q[DEPTH-1];
  assign mouse_left_out = l_q[DEPTH-1];
  assign left_press     = press_q;
  assign left_release   = release_q;
  assign pos_changed    = changed_q;
endmodule

// File: tb/tb_mouse_pos_pipe.sv
// tb_mouse_pos_pipe: directed and random stimulus against a sample-history reference model.
module tb_mouse_pos_pipe;
  localparam int W = 12, D = 2, XM = 1023, YM = 767;
`ifdef POS_CLAMP_EN
  localparam bit CL = 1'b1;
`else
  localparam bit CL = 1'b0;
`endif
  typedef struct packed {logic [W-1:0] x; logic [W-1:0] y; logic l;} smp_t;
  logic pclk = 0, rst_n = 0, freeze = 0, mouse_left_in = 0;
  logic [W-1:0] xpos_in = 0, ypos_in = 0;
  logic [W-1:0] xpos_out, ypos_out;
  logic mouse_left_out, left_press, left_release, pos_changed;
  int errs = 0, checks = 0;
  smp_t hist[$];
  smp_t s0 = '0, eo = '0;
  logic ep = 0, er = 0, ec = 0;
  logic [W-1:0] held;

  mouse_pos_pipe #(.WIDTH(W), .DEPTH(D), .X_MAX(XM), .Y_MAX(YM)) dut (
    .pclk(pclk), .rst_n(rst_n), .freeze(freeze),
    .xpos_in(xpos_in), .ypos_in(ypos_in), .mouse_left_in(mouse_left_in),
    .xpos_out(xpos_out), .ypos_out(ypos_out), .mouse_left_out(mouse_left_out),
    .left_press(left_press), .left_release(left_release), .pos_changed(pos_changed)
  );

  always #5 pclk = ~pclk;

  function automatic logic [W-1:0] clampv(logic [W-1:0] v, logic [W-1:0] m);
    return (CL && v > m) ? m : v;
  endfunction

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  // The output is the stage-0 sample taken DEPTH-1 edges earlier; pulses compare consecutive outputs.
  task automatic tick();
    smp_t n;
    @(posedge pclk);
    if (!rst_n) begin
      hist = {};
      for (int i = 0; i < D; i++) hist.push_back('0);
      s0 = '0; eo = '0; ep = 0; er = 0; ec = 0;
    end else begin
      if (!freeze) s0 = '{x: clampv(xpos_in, W'(XM)), y: clampv(ypos_in, W'(YM)), l: mouse_left_in};
      hist.push_back(s0);
      if (hist.size() > D) void'(hist.pop_front());
      n = hist[0];
      ep = !eo.l && n.l;
      er = eo.l && !n.l;
      ec = (n.x != eo.x) || (n.y != eo.y);
      eo = n;
    end
    #1;
    chk("xpos_out", 32'(xpos_out), 32'(eo.x));
    chk("ypos_out", 32'(ypos_out), 32'(eo.y));
    chk("mouse_left_out", 32'(mouse_left_out), 32'(eo.l));
    chk("left_press", 32'(left_press), 32'(ep));
    chk("left_release", 32'(left_release), 32'(er));
    chk("pos_changed", 32'(pos_changed), 32'(ec));
    chk("press_release_excl", 32'(left_press & left_release), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < D; i++) hist.push_back('0);
    // reset with live inputs
    rst_n = 0; xpos_in = 100; ypos_in = 50; mouse_left_in = 1;
    tick(); tick();
    chk("reset_x", 32'(xpos_out), 0);
    chk("reset_press", 32'(left_press), 0);
    rst_n = 1;
    tick(); tick();
    chk("first_x", 32'(xpos_out), 100);
    chk("first_y", 32'(ypos_out), 50);
    chk("first_press", 32'(left_press), 1);
    chk("first_changed", 32'(pos_changed), 1);
    tick();
    chk("first_press_done", 32'(left_press), 0);
    chk("first_changed_done", 32'(pos_changed), 0);
    // latency
    xpos_in = 200;
    tick();
    chk("lat_not_yet", 32'(xpos_out), 100);
    tick();
    chk("lat_x", 32'(xpos_out), 200);
    chk("lat_changed", 32'(pos_changed), 1);
    tick();
    chk("lat_changed_done", 32'(pos_changed), 0);
    // button cycle
    mouse_left_in = 0;
    repeat (3) tick();
    mouse_left_in = 1;
    repeat (3) tick();
    mouse_left_in = 0;
    repeat (4) tick();
    // back-to-back toggles
    for (int i = 0; i < 6; i++) begin
      mouse_left_in = ~mouse_left_in;
      tick();
    end
    // freeze while the input ramps
    freeze = 1;
    held = s0.x;
    for (int i = 0; i < 6; i++) begin
      xpos_in = W'(10 + i);
      tick();
    end
    chk("freeze_hold_x", 32'(xpos_out), 32'(held));
    chk("freeze_no_change", 32'(pos_changed), 0);
    freeze = 0;
    repeat (D) tick();
    chk("unfreeze_x", 32'(xpos_out), 15);
    // out-of-range coordinates
    xpos_in = 1500; ypos_in = 900;
    repeat (D) tick();
    chk("clamp_x", 32'(xpos_out), CL ? 1023 : 1500);
    chk("clamp_y", 32'(ypos_out), CL ? 767 : 900);
    // reset while a new sample sits in stage 0
    xpos_in = 300; ypos_in = 60;
    tick();
    rst_n = 0; xpos_in = 400; ypos_in = 70;
    tick();
    chk("midrst_x", 32'(xpos_out), 0);
    chk("midrst_changed", 32'(pos_changed), 0);
    rst_n = 1;
    tick(); tick();
    chk("midrst_after_x", 32'(xpos_out), 400);
    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      freeze = ($urandom_range(0, 4) == 0);
      mouse_left_in = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) != 0) begin
        xpos_in = W'($urandom_range(0, 4095));
        ypos_in = W'($urandom_range(0, 4095));
      end
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
